// File: rtl/bist_pkg.sv
// Shared BIST types: controller state encoding and the March C- element
// descriptor table consumed by march_rom.
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_OP_R, S_OP_C, S_OP_W, S_NEXT, S_DONE
  } state_t;

  localparam int NUM_ELEMS = 6;
  localparam int ELEM_W    = 3;

  typedef struct packed {
    logic up;      // 1 = ascending address order
    logic has_rd;
    logic rd_pat;  // expected data bit, replicated across the word
    logic has_wr;
    logic wr_pat;
  } elem_desc_t;

  localparam elem_desc_t E0_DESC = '{up: 1'b1, has_rd: 1'b0, rd_pat: 1'b0, has_wr: 1'b1, wr_pat: 1'b0};
  localparam elem_desc_t E1_DESC = '{up: 1'b1, has_rd: 1'b1, rd_pat: 1'b0, has_wr: 1'b1, wr_pat: 1'b1};
  localparam elem_desc_t E2_DESC = '{up: 1'b1, has_rd: 1'b1, rd_pat: 1'b1, has_wr: 1'b1, wr_pat: 1'b0};
  localparam elem_desc_t E3_DESC = '{up: 1'b0, has_rd: 1'b1, rd_pat: 1'b0, has_wr: 1'b1, wr_pat: 1'b1};
  localparam elem_desc_t E4_DESC = '{up: 1'b0, has_rd: 1'b1, rd_pat: 1'b1, has_wr: 1'b1, wr_pat: 1'b0};
  localparam elem_desc_t E5_DESC = '{up: 1'b1, has_rd: 1'b1, rd_pat: 1'b0, has_wr: 1'b0, wr_pat: 1'b0};

endpackage

// File: rtl/march_controller_if.sv
// Address-generator control and memory port bundle between the March
// sequencer (master) and the generator/memory side (slave).
interface march_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              ag_preset;
  logic              ag_en;
  logic              ag_up_down;
  logic              ag_carry;
  logic [ADDR_W-1:0] ag_address;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output ag_preset, ag_en, ag_up_down, mem_re, mem_we, mem_wdata,
    input  ag_carry, ag_address, mem_rdata
  );

  modport slave (
    input  ag_preset, ag_en, ag_up_down, mem_re, mem_we, mem_wdata,
    output ag_carry, ag_address, mem_rdata
  );
endinterface

// File: rtl/march_controller_rom.sv
// Combinational decode of the element index into its March C- descriptor.
module march_rom
  import bist_pkg::*;
(
  input  logic [ELEM_W-1:0] idx_i,
  output elem_desc_t        desc_o
);
  always_comb begin
    desc_o = '0;
    case (idx_i)
      3'd0: desc_o = E0_DESC;
      3'd1: desc_o = E1_DESC;
      3'd2: desc_o = E2_DESC;
      3'd3: desc_o = E3_DESC;
      3'd4: desc_o = E4_DESC;
      3'd5: desc_o = E5_DESC;
      default: desc_o = '0;
    endcase
  end
endmodule

// File: rtl/march_controller.sv
// March C- BIST sequencer. Define MARCH_FAIL_CAPTURE_EN to latch the address
// and read data of the first mismatch into fail_addr/fail_data.
module march_controller
  import bist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  march_if.master           bus,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  state_t            state_q, state_d;
  logic [ELEM_W-1:0] elem_q, elem_d;
  logic              fail_q, fail_d;
  logic              mismatch, run_clr;
  elem_desc_t        desc;

  march_rom u_rom (.idx_i(elem_q), .desc_o(desc));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      elem_q  <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    elem_d        = elem_q;
    fail_d        = fail_q;
    mismatch      = 1'b0;
    run_clr       = 1'b0;
    bus.ag_preset = 1'b0;
    bus.ag_en     = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SETUP;
          elem_d  = '0;
          fail_d  = 1'b0;
          run_clr = 1'b1;
        end
      end
      S_SETUP: begin
        bus.ag_preset = 1'b1;
        state_d       = desc.has_rd ? S_OP_R : S_OP_W;
      end
      S_OP_R: begin
        bus.mem_re = 1'b1;
        state_d    = S_OP_C;
      end
      S_OP_C: begin
        if (bus.mem_rdata != {DATA_W{desc.rd_pat}}) begin
          mismatch = 1'b1;
          fail_d   = 1'b1;
        end
        state_d = desc.has_wr ? S_OP_W : S_NEXT;
      end
      S_OP_W: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = {DATA_W{desc.wr_pat}};
        state_d       = S_NEXT;
      end
      S_NEXT: begin
        bus.ag_en = 1'b1;
        // carry flags the terminal address, which has just been fully processed
        if (bus.ag_carry) begin
          if (elem_q == ELEM_W'(NUM_ELEMS - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
            elem_d  = elem_q + 3'd1;
          end
        end else begin
          state_d = desc.has_rd ? S_OP_R : S_OP_W;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = (state_q == S_DONE);
  assign fail           = fail_q;
  assign bus.ag_up_down = busy ? desc.up : 1'b0;

`ifdef MARCH_FAIL_CAPTURE_EN
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;

  always_comb begin
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    if (run_clr) begin
      fail_addr_d = '0;
      fail_data_d = '0;
    end else if (mismatch && !fail_q) begin
      fail_addr_d = bus.ag_address;
      fail_data_d = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
`else
  assign fail_addr = '0;
  assign fail_data = '0;
`endif

endmodule

// File: tb/tb_march_controller.sv
// Scoreboarded bench for march_controller with behavioural address
// generator and an 8x256 memory with an optional stuck-at-0 fault.
module tb_march_controller;
  import bist_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int RUN = 5382;

  typedef struct {
    int          cycles;
    logic        fail;
    logic [7:0]  faddr;
    logic [7:0]  fdata;
    int          we;
    int          re;
  } exp_t;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [31:0]   outs;

  march_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  march_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  // address generator model
  logic [AW-1:0] addr_q;
  always @(posedge clk) begin
    if (reset)              addr_q <= '0;
    else if (bus.ag_preset) addr_q <= bus.ag_up_down ? 8'h00 : 8'hFF;
    else if (bus.ag_en)     addr_q <= bus.ag_up_down ? addr_q + 8'd1 : addr_q - 8'd1;
  end
  assign bus.ag_address = addr_q;
  assign bus.ag_carry   = bus.ag_up_down ? (addr_q == 8'hFF) : (addr_q == 8'h00);

  // memory model, bit 3 of 8'h5A optionally stuck at 0
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rdata_q;
  logic          fault_en = 1'b0;
  logic          fault_hit;
  assign fault_hit = fault_en && (addr_q == 8'h5A);
  always @(posedge clk) begin
    if (bus.mem_we) mem[addr_q] <= fault_hit ? (bus.mem_wdata & 8'hF7) : bus.mem_wdata;
    if (bus.mem_re) rdata_q     <= fault_hit ? (mem[addr_q] & 8'hF7) : mem[addr_q];
  end
  assign bus.mem_rdata = rdata_q;

  assign outs = {busy, done, fail, bus.ag_preset, bus.ag_en, bus.ag_up_down,
                 bus.mem_re, bus.mem_we, bus.mem_wdata, fail_addr, fail_data};

  int   n_tests = 0, n_fail = 0;
  int   ncyc = 0, ref_cyc = 0, we_cnt = 0, re_cnt = 0, done_cnt = 0;
  int   preset_cnt = 0;
  logic done_prev = 1'b0, dir_en = 1'b0, e3_re_seen = 1'b0;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // monitor: cycle count, strobe counts, direction probes, scoreboard pop on done
  always @(negedge clk) begin
    ncyc++;
    if (bus.mem_we) we_cnt++;
    if (bus.mem_re) re_cnt++;
    if (dir_en) begin
      if (bus.ag_preset) begin
        preset_cnt++;
        if (preset_cnt == 4) chk("e3_setup_up_down", 32'(bus.ag_up_down), 32'd0);
      end
      if (preset_cnt == 4 && bus.mem_re && !e3_re_seen) begin
        e3_re_seen = 1'b1;
        chk("e3_first_read_addr", 32'(bus.ag_address), 32'hFF);
      end
      if (preset_cnt == 4 && bus.ag_en && bus.ag_carry)
        chk("e3_last_next_dir_addr", {23'd0, bus.ag_up_down, bus.ag_address}, 32'd0);
    end
    if (!reset && done && !done_prev) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("done_latency", 32'(ncyc - ref_cyc), 32'(e.cycles));
        chk("fail",         32'(fail),           32'(e.fail));
        chk("fail_addr",    32'(fail_addr),      32'(e.faddr));
        chk("fail_data",    32'(fail_data),      32'(e.fdata));
        chk("we_count",     32'(we_cnt),         32'(e.we));
        chk("re_count",     32'(re_cnt),         32'(e.re));
      end
    end
    done_prev = done;
  end

  task automatic push_exp(input logic f, input logic [7:0] fa, input logic [7:0] fd);
    exp_t e;
    e.cycles = RUN; e.fail = f; e.faddr = fa; e.fdata = fd; e.we = 1280; e.re = 1280;
    sb_q.push_back(e);
  endtask

  task automatic run_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    ref_cyc = ncyc; we_cnt = 0; re_cnt = 0; preset_cnt = 0; e3_re_seen = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int c0;
    c0 = done_cnt;
    for (int i = 0; i < RUN + 200 && done_cnt == c0; i++) begin
      @(negedge clk); #1;
    end
    chk("done_seen", 32'(done_cnt - c0), 32'd1);
  endtask

  initial begin
    logic [7:0] exp_fa, exp_fd;
`ifdef MARCH_FAIL_CAPTURE_EN
    exp_fa = 8'h5A; exp_fd = 8'hF7;
`else
    exp_fa = 8'h00; exp_fd = 8'h00;
`endif
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", outs, 32'd0);
    reset = 1'b0;
    @(negedge clk); #1 chk("idle_outputs", outs, 32'd0);

    // fault-free run with direction probes during E3
    dir_en = 1'b1;
    push_exp(1'b0, 8'h00, 8'h00);
    run_start();
    chk("busy_in_setup", {30'd0, busy, done}, 32'd2);
    wait_done();
    dir_en = 1'b0;
    repeat (5) @(negedge clk);
    #1 chk("done_held", {30'd0, busy, done}, 32'd1);

    // stuck-at-0 bit 3 at 8'h5A
    fault_en = 1'b1;
    push_exp(1'b1, exp_fa, exp_fd);
    run_start();
    wait_done();
    fault_en = 1'b0;

    // start from DONE clears done and fail
    push_exp(1'b0, 8'h00, 8'h00);
    run_start();
    chk("restart_clears", {29'd0, busy, done, fail}, 32'd4);
    wait_done();

    // reset aborts a run at cycle 3000
    run_start();
    repeat (3000) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk); #1 chk("abort_outputs", outs, 32'd0);
    reset = 1'b0;
    @(negedge clk); #1 chk("post_abort_idle", outs, 32'd0);
    push_exp(1'b0, 8'h00, 8'h00);
    run_start();
    wait_done();

    // start while busy is ignored
    push_exp(1'b0, 8'h00, 8'h00);
    run_start();
    repeat (100) @(negedge clk);
    pulse_start();
    repeat (4000) @(negedge clk);
    pulse_start();
    wait_done();

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
